// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for a 5-stage F/D/EX/MEM/WB core: PC, stage valids, load-use stall, branch flush, EX forwarding.
// Optional saturating performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int                  PC_BITS    = 5,
  parameter int                  REG_ADDR_W = 5,
  parameter logic [PC_BITS-1:0]  RESET_PC   = '0,
  parameter int                  CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] D_ra,
  input  logic [REG_ADDR_W-1:0] D_rb,
  input  logic                  D_use_ra,
  input  logic                  D_use_rb,
  input  logic [REG_ADDR_W-1:0] D_rd,
  input  logic                  D_we,
  input  logic                  D_ld,
  input  logic                  EX_taken,
  input  logic [PC_BITS-1:0]    EX_alt_pc,
  output logic [PC_BITS-1:0]    F_pc,
  output logic [PC_BITS-1:0]    D_pc,
  output logic                  D_valid,
  output logic                  EX_valid,
  output logic                  MEM_valid,
  output logic                  WB_valid,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            EX_fwd_a,
  output logic [1:0]            EX_fwd_b,
  output logic [REG_ADDR_W-1:0] WB_rd,
  output logic                  WB_we,
  output logic [CNT_W-1:0]      perf_stall,
  output logic [CNT_W-1:0]      perf_flush,
  output logic [CNT_W-1:0]      perf_retire
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } stage_t;

  logic [PC_BITS-1:0]    f_pc_q, d_pc_q;
  logic                  d_valid_q;
  stage_t                ex_q, mem_q;
  logic [REG_ADDR_W-1:0] ex_ra_q, ex_rb_q;
  logic                  wb_valid_q, wb_we_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  load_use;

  // MEM result wins over WB; loads in MEM have no data yet and never forward.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src, input stage_t mem,
                                         input logic wb_v, input logic wb_w,
                                         input logic [REG_ADDR_W-1:0] wb_r);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if (mem.valid && mem.we && !mem.ld && mem.rd == src) sel = 2'd1;
      else if (wb_v && wb_w && wb_r == src)                sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_q.valid && ex_q.ld && ex_q.we && (ex_q.rd != '0) && d_valid_q &&
               ((D_use_ra && D_ra == ex_q.rd) || (D_use_rb && D_rb == ex_q.rd));
    flush    = ex_q.valid && EX_taken;
    stall    = load_use && !flush;
    EX_fwd_a = fwd_sel(ex_ra_q, mem_q, wb_valid_q, wb_we_q, wb_rd_q);
    EX_fwd_b = fwd_sel(ex_rb_q, mem_q, wb_valid_q, wb_we_q, wb_rd_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_pc_q     <= RESET_PC;
      d_pc_q     <= RESET_PC;
      d_valid_q  <= 1'b0;
      ex_q       <= '0;
      ex_ra_q    <= '0;
      ex_rb_q    <= '0;
      mem_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      mem_q      <= ex_q;
      wb_valid_q <= mem_q.valid;
      wb_we_q    <= mem_q.we;
      wb_rd_q    <= mem_q.rd;
      if (flush) begin
        f_pc_q    <= EX_alt_pc;
        d_valid_q <= 1'b0;
        ex_q      <= '0;
        ex_ra_q   <= '0;
        ex_rb_q   <= '0;
      end else if (stall) begin
        // F and D hold; EX becomes a cleared bubble so it neither writes nor forwards.
        ex_q    <= '0;
        ex_ra_q <= '0;
        ex_rb_q <= '0;
      end else begin
        f_pc_q    <= f_pc_q + PC_BITS'(1);
        d_pc_q    <= f_pc_q;
        d_valid_q <= 1'b1;
        ex_q      <= '{valid: d_valid_q, rd: D_rd, we: D_we, ld: D_ld};
        ex_ra_q   <= D_use_ra ? D_ra : '0;
        ex_rb_q   <= D_use_rb ? D_rb : '0;
      end
    end
  end

  assign F_pc      = f_pc_q;
  assign D_pc      = d_pc_q;
  assign D_valid   = d_valid_q;
  assign EX_valid  = ex_q.valid;
  assign MEM_valid = mem_q.valid;
  assign WB_valid  = wb_valid_q;
  assign WB_rd     = wb_rd_q;
  assign WB_we     = wb_valid_q && wb_we_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      cnt_retire_q <= '0;
    end else begin
      if (stall && cnt_stall_q != '1)       cnt_stall_q  <= cnt_stall_q + CNT_W'(1);
      if (flush && cnt_flush_q != '1)       cnt_flush_q  <= cnt_flush_q + CNT_W'(1);
      if (wb_valid_q && cnt_retire_q != '1) cnt_retire_q <= cnt_retire_q + CNT_W'(1);
    end
  end

  assign perf_stall  = cnt_stall_q;
  assign perf_flush  = cnt_flush_q;
  assign perf_retire = cnt_retire_q;
`else
  assign perf_stall  = '0;
  assign perf_flush  = '0;
  assign perf_retire = '0;
`endif

endmodule
